// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared divider state codes, handshake levels and bus widths
package div_seq_pkg;
    localparam logic [1:0] DivFree           = 2'b00;
    localparam logic [1:0] DivByZero         = 2'b01;
    localparam logic [1:0] DivOn             = 2'b10;
    localparam logic [1:0] DivEnd            = 2'b11;
    localparam logic       DivStart          = 1'b1;
    localparam logic       DivStop           = 1'b0;
    localparam logic       DivResultReady    = 1'b1;
    localparam logic       DivResultNotReady = 1'b0;
    localparam int         DoubleRegBus      = 64;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (trial subtract, keep or restore)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH+1:0] diff;
    assign diff  = {1'b0, rem_i} - {2'b00, divisor_i};
    assign q_o   = ~diff[WIDTH+1];
    assign rem_o = WIDTH'(q_o ? diff : {1'b0, rem_i});
endmodule

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divider sequencer for DIV/DIVU; DIV_EARLY_OUT_EN enables the |op1|<|op2| shortcut
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);
    localparam logic [5:0] LAST = 6'(WIDTH - 1);
    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic               negq_q, negq_d, negr_q, negr_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0]   mag1, mag2, step_rem, quot_fin, quot_fix, rem_fix;
    logic               step_q, early;
    assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
    assign early = mag1 < mag2;
`else
    assign early = 1'b0;
`endif
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     ({rem_q, dvd_q[WIDTH-1]}),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );
    assign quot_fin = {dvd_q[WIDTH-2:0], step_q};
    assign quot_fix = negq_q ? -quot_fin : quot_fin;
    assign rem_fix  = negr_q ? -step_rem : step_rem;
    assign result_o = res_q;
    assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
    assign busy_o   = (state_q == DivByZero) || (state_q == DivOn);
    // next-state: annul overrides any active state, otherwise step the FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        if (annul_i && state_q != DivFree) begin
            state_d = DivFree;
            res_d   = '0;
        end else begin
            case (state_q)
                DivFree: if (start_i == DivStart && !annul_i) begin
                    dvd_d  = mag1;
                    dvs_d  = mag2;
                    rem_d  = '0;
                    cnt_d  = '0;
                    negq_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    negr_d = signed_div_i && opdata1_i[WIDTH-1];
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else if (early) begin
                        state_d = DivEnd;
                        res_d   = {opdata1_i, {WIDTH{1'b0}}};
                    end else begin
                        state_d = DivOn;
                    end
                end
                DivByZero: begin
                    state_d = DivEnd;
                    res_d   = '0;
                end
                DivOn: begin
                    dvd_d = quot_fin;
                    rem_d = step_rem;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        state_d = DivEnd;
                        res_d   = {rem_fix, quot_fix};
                    end
                end
                DivEnd: if (start_i == DivStop) state_d = DivFree;
            endcase
        end
    end
    // state and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DivFree;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random DIV/DIVU checks against an arithmetic reference model
module tb_div_seq;
  logic clk = 1'b0;
  logic rst, signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic ready_o, busy_o;
  int errors = 0;
  int checks = 0;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic logic [31:0] absv(bit s, logic [31:0] x);
    return (s && x[31]) ? 32'(-x) : x;
  endfunction
  function automatic logic [63:0] model(bit s, logic [31:0] a, logic [31:0] b);
    if (b == 0) return 64'h0;
    if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return 64'h00000000_80000000;
    if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction
  function automatic int model_lat(bit s, logic [31:0] a, logic [31:0] b);
    if (b == 0) return 1;
    if (EARLY && absv(s, a) < absv(s, b)) return 0;
    return 32;
  endfunction
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] want;
    int lat, want_lat;
    bit busy_ok;
    want = model(s, a, b);
    want_lat = model_lat(s, a, b);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    busy_ok = 1'b1;
    while (!ready_o && lat < 40) begin
      if (!busy_o) busy_ok = 1'b0;
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, want_lat);
    chk("busy_during", busy_ok, 1'b1);
    chk("result", result_o, want);
    chk("busy_at_end", busy_o, 1'b0);
    @(posedge clk); #1;
    chk("hold_ready", ready_o, 1'b1);
    chk("hold_result", result_o, want);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", ready_o, 1'b0);
    chk("idle_result", result_o, want);
  endtask
  initial begin
    bit rose;
    logic [31:0] a, b;
    rst = 1'b1; signed_div_i = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result_o, 64'h0);
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    @(negedge clk); rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7);
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
    run_div(1'b0, 32'd1234, 32'd0);
    run_div(1'b1, 32'd5, 32'd9);
    run_div(1'b0, 32'd5, 32'd9);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE);
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    rose = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready_o) rose = 1'b1;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul_ready", ready_o | rose, 1'b0);
    chk("annul_busy", busy_o, 1'b0);
    chk("annul_result", result_o, 64'h0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    chk("annul_idle_busy", busy_o, 1'b0);
    run_div(1'b0, 32'd9, 32'd3);
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd13; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_result", result_o, 64'h0);
    chk("midrst_ready", ready_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = 32'($signed(-$urandom_range(1, 20)));
        default: b = $urandom;
      endcase
      if (i % 7 == 0) a = $urandom_range(0, 30);
      run_div(1'($urandom), a, b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
